// File: rtl/gray_input_conditioner.sv
// gray_input_conditioner: synchronise, debounce and decode an asynchronous Gray-coded input word
// Ports:
//   clk      - sole clock
//   rst_n    - synchronous reset, active low
//   gray_in  - asynchronous Gray word from the pins
//   gray_out - last committed Gray word
//   bin_out  - binary of gray_out, registered
//   stable   - high while no candidate is being debounced
//   changed  - one-cycle pulse on every commit
//   step_up  - one-cycle pulse when the committed value moved +1 (mod 2^WIDTH)
//   step_dn  - one-cycle pulse when the committed value moved -1 (mod 2^WIDTH)
//   gray_err - one-cycle pulse when a commit changed more than one Gray bit
module gray_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             stable,
    output logic             changed,
    output logic             step_up,
    output logic             step_dn,
    output logic             gray_err
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {ST_STABLE, ST_SETTLING} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_gq, r_cand, r_bin;
    logic [CW-1:0]    r_cnt;
    logic             r_primed, r_changed, r_up, r_dn, r_err;
    logic [WIDTH-1:0] w_s, w_diff, w_new_bin;
    logic             w_load, w_inc, w_commit, w_multi;

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        for (int i = 0; i < WIDTH; i++)
            g2b[i] = ^(g >> i);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                r_sync[i] <= '0;
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_diff    = r_gq ^ r_cand;
    // Clearing the lowest set bit leaves something only if two or more bits differ.
    assign w_multi   = (w_diff & (w_diff - ONE)) != '0;
    assign w_new_bin = g2b(r_cand);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_STABLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_STABLE)
            w_next = (w_s != r_gq) ? ST_SETTLING : ST_STABLE;
        else if (w_s == r_gq || w_commit)
            w_next = ST_STABLE;
    end

    // Settling priority: glitch reject, then candidate restart, then commit, then count.
    always_comb begin
        stable   = r_state == ST_STABLE;
        w_load   = (w_s != r_gq) && (stable || w_s != r_cand);
        w_commit = !stable && w_s != r_gq && w_s == r_cand && r_cnt == CNT_LAST;
        w_inc    = !stable && w_s != r_gq && w_s == r_cand && r_cnt != CNT_LAST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gq      <= '0;
            r_cand    <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_changed <= 1'b0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_changed <= w_commit;
            r_up      <= w_commit && !w_multi && w_new_bin == r_bin + ONE;
            r_dn      <= w_commit && !w_multi && w_new_bin == r_bin - ONE;
            r_err     <= w_commit && w_multi && r_primed;
            if (w_load) begin
                r_cand <= w_s;
                r_cnt  <= '0;
            end else if (w_inc) begin
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_gq     <= r_cand;
                r_bin    <= w_new_bin;
                r_primed <= 1'b1;
            end
        end
    end

    assign gray_out = r_gq;
    assign bin_out  = r_bin;
    assign changed  = r_changed;
    assign step_up  = r_up;
    assign step_dn  = r_dn;
    assign gray_err = r_err;
endmodule

// File: tb/tb_gray_input_conditioner.sv
// tb_gray_input_conditioner: directed self-checking bench for gray_input_conditioner
module tb_gray_input_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = 4'b0000;
    logic [3:0] gray_out, bin_out, gray_out1, bin_out1;
    logic       stable, changed, step_up, step_dn, gray_err;
    logic       stable1, changed1, step_up1, step_dn1, gray_err1;
    int         n_vec = 0, n_bad = 0;
    int         n_chg = 0, n_up = 0, n_dn = 0, n_err = 0, n_unst = 0;
    int         s_chg, s_up, s_dn, s_err, s_unst;

    gray_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_out(gray_out), .bin_out(bin_out),
        .stable(stable), .changed(changed), .step_up(step_up), .step_dn(step_dn), .gray_err(gray_err)
    );

    gray_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_out(gray_out1), .bin_out(bin_out1),
        .stable(stable1), .changed(changed1), .step_up(step_up1), .step_dn(step_dn1), .gray_err(gray_err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed === 1'b1) n_chg++;
        if (step_up === 1'b1) n_up++;
        if (step_dn === 1'b1) n_dn++;
        if (gray_err === 1'b1) n_err++;
        if (stable === 1'b0) n_unst++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap;
        s_chg = n_chg; s_up = n_up; s_dn = n_dn; s_err = n_err; s_unst = n_unst;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        gray_in = 4'b0000;
        wait_n(3);
        rst_n = 1'b1;
    endtask

    task automatic commit_chk(input string tag, input logic [3:0] g, input logic [3:0] b,
                              input logic up, input logic dn, input logic err);
        gray_in = g;
        wait_n(18);
        check({tag, "_early"}, changed, 0);
        wait_n(1);
        check({tag, "_gray"}, gray_out, g);
        check({tag, "_bin"}, bin_out, b);
        check({tag, "_chg"}, changed, 1);
        check({tag, "_up"}, step_up, up);
        check({tag, "_dn"}, step_dn, dn);
        check({tag, "_err"}, gray_err, err);
        wait_n(1);
        check({tag, "_chg_end"}, changed, 0);
        wait_n(5);
    endtask

    initial begin
        wait_n(3);
        check("rst_stable", stable, 1);
        check("rst_gray", gray_out, 0);
        check("rst_bin", bin_out, 0);
        check("rst_pulses", {changed, step_up, step_dn, gray_err}, 0);
        rst_n = 1'b1;
        snap();
        wait_n(50);
        check("idle_pulses", n_chg - s_chg + n_up - s_up + n_dn - s_dn + n_err - s_err, 0);
        check("idle_stable", stable, 1);
        check("idle_gray", gray_out, 0);

        gray_in = 4'b0001;
        wait_n(2);
        check("lat_stable_e2", stable, 1);
        wait_n(1);
        check("lat_stable_e3", stable, 0);
        wait_n(1);
        check("d1_chg", changed1, 1);
        check("d1_gray", gray_out1, 4'b0001);
        check("d1_up", step_up1, 1);
        wait_n(14);
        check("lat_e18_chg", changed, 0);
        check("lat_e18_gray", gray_out, 0);
        wait_n(1);
        check("lat_e19_gray", gray_out, 4'b0001);
        check("lat_e19_bin", bin_out, 4'b0001);
        check("lat_e19_chg", changed, 1);
        check("lat_e19_up", step_up, 1);
        check("lat_e19_dn", step_dn, 0);
        check("lat_e19_err", gray_err, 0);
        check("lat_e19_stable", stable, 1);
        wait_n(1);
        check("lat_e20_pulse", {changed, step_up}, 0);
        wait_n(5);

        commit_chk("back0", 4'b0000, 4'b0000, 0, 1, 0);
        commit_chk("wrap_dn", 4'b1000, 4'b1111, 0, 1, 0);
        commit_chk("wrap_up", 4'b0000, 4'b0000, 1, 0, 0);
        commit_chk("to1", 4'b0001, 4'b0001, 1, 0, 0);

        snap();
        for (int k = 0; k < 20; k++) begin
            gray_in = k[0] ? 4'b0001 : 4'b0011;
            wait_n(5);
        end
        gray_in = 4'b0001;
        wait_n(30);
        check("bounce_chg", n_chg - s_chg, 0);
        check("bounce_unst", (n_unst - s_unst) > 0, 1);
        check("bounce_stable", stable, 1);
        check("bounce_gray", gray_out, 4'b0001);

        commit_chk("viol", 4'b0111, 4'b0101, 0, 0, 1);

        do_reset();
        commit_chk("unprimed", 4'b0110, 4'b0100, 0, 0, 0);

        do_reset();
        gray_in = 4'b0011;
        wait_n(9);
        rst_n = 1'b0;
        wait_n(1);
        check("mid_rst_stable", stable, 1);
        check("mid_rst_gray", gray_out, 0);
        rst_n = 1'b1;
        snap();
        wait_n(18);
        check("mid_rst_early", n_chg - s_chg, 0);
        check("mid_rst_e18_stable", stable, 0);
        wait_n(1);
        check("mid_rst_chg", changed, 1);
        check("mid_rst_gray_c", gray_out, 4'b0011);
        check("mid_rst_bin", bin_out, 4'b0010);
        check("mid_rst_err", {gray_err, step_up, step_dn}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
